// File: rtl/shift_seq_engine.sv
// Multi-mode shift register with a counted-shift command sequencer.
// One command is taken per valid/ready handshake. LOAD and CLEAR act on the
// accept edge. A shift op repeats one bit per clock, cnt times.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready for a command, cmd_ready high
// S_SHIFT | performing the latched shift op, rem shifts still to go
// S_DONE  | one-cycle completion pulse, command inputs ignored
module shift_seq_engine #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    op,
    input  logic [CW-1:0] cnt,
    input  logic [N-1:0]  d,
    input  logic          sin_r,
    input  logic          sin_l,
    output logic [N-1:0]  q,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_SLL   = 3'b001;
    localparam logic [2:0] OP_SRL   = 3'b010;
    localparam logic [2:0] OP_SRA   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;

    localparam logic [CW-1:0] REM_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] REM_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    op_r, op_nxt;
    logic [CW-1:0] rem, rem_nxt;
    logic [N-1:0]  q_nxt;
    logic          sout_nxt;
    logic [N-1:0]  shift_q;
    logic          shift_out;

    // Handshake and status decode straight from the state register.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // One-bit shift of the current contents for the latched op; serial
    // inputs are taken live so a chained neighbour can feed each step.
    always_comb begin
        shift_q   = q;
        shift_out = sout;
        case (op_r)
            OP_SLL: begin
                shift_q   = {q[N-2:0], sin_r};
                shift_out = q[N-1];
            end
            OP_SRL: begin
                shift_q   = {sin_l, q[N-1:1]};
                shift_out = q[0];
            end
            OP_SRA: begin
                shift_q   = {q[N-1], q[N-1:1]};
                shift_out = q[0];
            end
            OP_ROL: begin
                shift_q   = {q[N-2:0], q[N-1]};
                shift_out = q[N-1];
            end
            OP_ROR: begin
                shift_q   = {q[0], q[N-1:1]};
                shift_out = q[0];
            end
            default: begin
                shift_q   = q;
                shift_out = sout;
            end
        endcase
    end

    // Next-state, register and down-counter update.
    always_comb begin
        state_nxt = state;
        op_nxt    = op_r;
        rem_nxt   = rem;
        q_nxt     = q;
        sout_nxt  = sout;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_nxt  = op;
                    rem_nxt = cnt;
                    case (op)
                        OP_LOAD: begin
                            q_nxt     = d;
                            state_nxt = S_DONE;
                        end
                        OP_CLEAR: begin
                            q_nxt     = '0;
                            state_nxt = S_DONE;
                        end
                        OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: begin
                            state_nxt = (cnt == REM_ZERO) ? S_DONE : S_SHIFT;
                        end
                        default: state_nxt = S_DONE;
                    endcase
                end
            end
            S_SHIFT: begin
                q_nxt    = shift_q;
                sout_nxt = shift_out;
                rem_nxt  = rem - REM_ONE;
                if (rem == REM_ONE) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_r  <= '0;
            rem   <= '0;
            q     <= '0;
            sout  <= 1'b0;
        end else begin
            state <= state_nxt;
            op_r  <= op_nxt;
            rem   <= rem_nxt;
            q     <= q_nxt;
            sout  <= sout_nxt;
        end
    end

endmodule

// File: tb/tb_shift_seq_engine.sv
// Bench for shift_seq_engine: stimulus pushes expected {q, sout} per command,
// a monitor pops and compares on every done pulse.
module tb_shift_seq_engine;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] op;
    logic [3:0] cnt;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;

    int checks;
    int failures;
    int done_cnt;
    logic [8:0] sb[$];

    shift_seq_engine #(.N(8), .CW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .op        (op),
        .cnt       (cnt),
        .d         (d),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .q         (q),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    initial begin
        logic [8:0] e;
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst && done === 1'b1) begin
                done_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_done actual_q=%0h actual_sout=%0b expected=none", q, sout);
                end else begin
                    e = sb.pop_front();
                    if ({q, sout} !== e) begin
                        failures++;
                        $display("FAIL sb_result actual_q=%0h actual_sout=%0b expected_q=%0h expected_sout=%0b",
                                 q, sout, e[8:1], e[0]);
                    end
                end
                checks++;
                if (cmd_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL done_ready_overlap actual=%0b expected=0", cmd_ready);
                end
            end
        end
    end

    task automatic run_cmd(input string name, input logic [2:0] o, input logic [3:0] c,
                           input logic [7:0] dd, input logic [7:0] eq, input logic es,
                           input int exp_lat, input bit hold_clear);
        int  lat;
        int  busy_n;
        bit  seen;
        sb.push_back({eq, es});
        @(negedge clk);
        op        = o;
        cnt       = c;
        d         = dd;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold_clear) begin
            op  = 3'b110;
            cnt = 4'd0;
            d   = 8'h00;
        end else begin
            cmd_valid = 1'b0;
        end
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) seen = 1'b1;
        end
        cmd_valid = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done expected=done_within_40", name);
        end else begin
            chk({name, "_latency"}, lat, exp_lat);
            chk({name, "_busy_cycles"}, busy_n, exp_lat);
        end
        @(negedge clk);
        chk({name, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
        chk({name, "_done_after"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int dc;
        checks    = 0;
        failures  = 0;
        cmd_valid = 1'b0;
        op        = 3'b000;
        cnt       = 4'd0;
        d         = 8'h00;
        sin_r     = 1'b0;
        sin_l     = 1'b0;
        rst       = 1'b1;
        #3;
        chk("rst_q", q, 0);
        chk("rst_sout", sout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        run_cmd("load_a5", 3'b000, 4'd0, 8'hA5, 8'hA5, 1'b0, 1, 1'b0);

        // Asynchronous reset pulse in the middle of an idle cycle.
        #2 rst = 1'b1;
        #1;
        chk("idle_rst_q", q, 0);
        chk("idle_rst_ready", cmd_ready, 1);
        chk("idle_rst_busy", busy, 0);
        #1 rst = 1'b0;

        run_cmd("load_a5_again", 3'b000, 4'd0, 8'hA5, 8'hA5, 1'b0, 1, 1'b0);
        sin_r = 1'b1;
        run_cmd("sll3", 3'b001, 4'd3, 8'h00, 8'h2F, 1'b1, 4, 1'b0);
        sin_r = 1'b0;
        run_cmd("load_80", 3'b000, 4'd0, 8'h80, 8'h80, 1'b1, 1, 1'b0);
        run_cmd("sra2", 3'b011, 4'd2, 8'h00, 8'hE0, 1'b0, 3, 1'b0);
        run_cmd("load_01", 3'b000, 4'd0, 8'h01, 8'h01, 1'b0, 1, 1'b0);
        run_cmd("ror9", 3'b101, 4'd9, 8'h00, 8'h80, 1'b1, 10, 1'b0);
        run_cmd("sll0", 3'b001, 4'd0, 8'h00, 8'h80, 1'b1, 1, 1'b0);
        run_cmd("reserved", 3'b111, 4'd5, 8'h55, 8'h80, 1'b1, 1, 1'b0);
        run_cmd("load_81", 3'b000, 4'd0, 8'h81, 8'h81, 1'b1, 1, 1'b0);
        run_cmd("rol1", 3'b100, 4'd1, 8'h00, 8'h03, 1'b1, 2, 1'b0);
        run_cmd("load_3c", 3'b000, 4'd0, 8'h3C, 8'h3C, 1'b1, 1, 1'b0);
        sin_l = 1'b1;
        run_cmd("srl4_hold_clear", 3'b010, 4'd4, 8'h00, 8'hF3, 1'b1, 5, 1'b1);
        sin_l = 1'b0;
        @(negedge clk);
        chk("held_clear_ignored_q", q, 32'hF3);
        run_cmd("clear", 3'b110, 4'd0, 8'h00, 8'h00, 1'b1, 1, 1'b0);
        run_cmd("load_ff", 3'b000, 4'd0, 8'hFF, 8'hFF, 1'b1, 1, 1'b0);
        run_cmd("srl15_drain", 3'b010, 4'd15, 8'h00, 8'h00, 1'b0, 16, 1'b0);
        run_cmd("load_80b", 3'b000, 4'd0, 8'h80, 8'h80, 1'b0, 1, 1'b0);
        run_cmd("sra15_sat", 3'b011, 4'd15, 8'h00, 8'hFF, 1'b1, 16, 1'b0);
        run_cmd("load_f0", 3'b000, 4'd0, 8'hF0, 8'hF0, 1'b1, 1, 1'b0);

        // SRL cnt=5 interrupted by reset after two shifts.
        dc = done_cnt;
        @(negedge clk);
        op        = 3'b010;
        cnt       = 4'd5;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("mid_two_shifts_q", q, 32'h3C);
        rst = 1'b1;
        #1;
        chk("mid_rst_q", q, 0);
        chk("mid_rst_sout", sout, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_rst_no_done", done_cnt, dc);
        run_cmd("load_5a", 3'b000, 4'd0, 8'h5A, 8'h5A, 1'b0, 1, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
